// File: rtl/onewire_pkg.sv
// Shared types and default timing for the 1-Wire bit engine and its timer users.
package onewire_pkg;

    // Command codes as presented by the byte-level controller.
    typedef enum logic [1:0] {
        OW_RESET  = 2'd0,
        OW_WRITE0 = 2'd1,
        OW_WRITE1 = 2'd2,
        OW_READ   = 2'd3
    } cmd_t;

    // Bit engine sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_PDS,
        RST_REC,
        SLOT_LOW,
        SLOT_SMP,
        SLOT_REC,
        RESP
    } state_t;

    // Width of the one-shot timer delay field.
    localparam int TMR_W = 16;

    // Default bus timing in microseconds.
    localparam int unsigned OW_T_RSTL_US = 480;
    localparam int unsigned OW_T_PDS_US  = 70;
    localparam int unsigned OW_T_RSTR_US = 410;
    localparam int unsigned OW_T_W0L_US  = 60;
    localparam int unsigned OW_T_W1L_US  = 6;
    localparam int unsigned OW_T_RDS_US  = 9;
    localparam int unsigned OW_T_SLOT_US = 70;

endpackage

// File: rtl/onewire_sync2.sv
// Two-flop synchronizer for the raw DQ level; resets to the released (high) level.
module onewire_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous bus level through two flops before anyone samples it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: reset to 1, the pulled-up idle level, so a fresh engine never sees a phantom low.
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            // NOTE: non-blocking here so q takes the old meta, giving two real stages.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/onewire_bit_engine.sv
// Bit-level 1-Wire master: sequences RESET / WRITE0 / WRITE1 / READ through the
// microsecond one-shot timer and returns presence or read data.
module onewire_bit_engine
    import onewire_pkg::*;
#(
    parameter int unsigned T_RSTL_US = OW_T_RSTL_US,
    parameter int unsigned T_PDS_US  = OW_T_PDS_US,
    parameter int unsigned T_RSTR_US = OW_T_RSTR_US,
    parameter int unsigned T_W0L_US  = OW_T_W0L_US,
    parameter int unsigned T_W1L_US  = OW_T_W1L_US,
    parameter int unsigned T_RDS_US  = OW_T_RDS_US,
    parameter int unsigned T_SLOT_US = OW_T_SLOT_US
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    output logic             rsp_valid,
    output logic             rsp_bit,
    output logic             busy,
    input  logic             dq_in,
    output logic             dq_oe,
    output logic             tmr_start,
    output logic [TMR_W-1:0] tmr_delay_us,
    input  logic             tmr_done
);

    localparam logic [TMR_W-1:0] RSTL_US = TMR_W'(T_RSTL_US);
    localparam logic [TMR_W-1:0] PDS_US  = TMR_W'(T_PDS_US);
    localparam logic [TMR_W-1:0] RSTR_US = TMR_W'(T_RSTR_US);
    localparam logic [TMR_W-1:0] W0L_US  = TMR_W'(T_W0L_US);
    localparam logic [TMR_W-1:0] W1L_US  = TMR_W'(T_W1L_US);
    localparam logic [TMR_W-1:0] RDS_US  = TMR_W'(T_RDS_US);
    localparam logic [TMR_W-1:0] SLOT_US = TMR_W'(T_SLOT_US);

    state_t           state;
    cmd_t             cmd_q;
    logic             sample_q;
    logic             dq_sync;
    logic             phase_done;
    logic [TMR_W-1:0] rec_us;

    // Low time of a slot: only WRITE0 holds the bus long; WRITE1 and READ share the short pulse.
    function automatic logic [TMR_W-1:0] low_time(input cmd_t c);
        return (c == OW_WRITE0) ? W0L_US : W1L_US;
    endfunction

    onewire_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dq_in),
        .q   (dq_sync)
    );

    // A done seen while our own start is still out cannot belong to the phase just entered.
    assign phase_done = tmr_done && !tmr_start;

    // Recovery fills the rest of the slot; wraps modulo 2^16 if the timing is misconfigured.
    assign rec_us = SLOT_US - low_time(cmd_q) - ((cmd_q == OW_READ) ? RDS_US : '0);

    // Command sequencer: every output is registered so DQ and the timer strobe are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cmd_q        <= OW_RESET;
            sample_q     <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_bit      <= 1'b0;
            dq_oe        <= 1'b0;
            tmr_start    <= 1'b0;
            tmr_delay_us <= '0;
        end else begin
            tmr_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_q     <= cmd_t'(cmd);
                        sample_q  <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        dq_oe     <= 1'b1;
                        tmr_start <= 1'b1;
                        if (cmd_t'(cmd) == OW_RESET) begin
                            state        <= RST_LOW;
                            tmr_delay_us <= RSTL_US;
                        end else begin
                            state        <= SLOT_LOW;
                            tmr_delay_us <= low_time(cmd_t'(cmd));
                        end
                    end
                end
                RST_LOW: begin
                    if (phase_done) begin
                        state        <= RST_PDS;
                        dq_oe        <= 1'b0;
                        tmr_start    <= 1'b1;
                        tmr_delay_us <= PDS_US;
                    end
                end
                RST_PDS: begin
                    if (phase_done) begin
                        state        <= RST_REC;
                        sample_q     <= ~dq_sync;
                        tmr_start    <= 1'b1;
                        tmr_delay_us <= RSTR_US;
                    end
                end
                RST_REC: begin
                    if (phase_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_bit   <= sample_q;
                    end
                end
                SLOT_LOW: begin
                    if (phase_done) begin
                        dq_oe     <= 1'b0;
                        tmr_start <= 1'b1;
                        if (cmd_q == OW_READ) begin
                            state        <= SLOT_SMP;
                            tmr_delay_us <= RDS_US;
                        end else begin
                            state        <= SLOT_REC;
                            tmr_delay_us <= rec_us;
                        end
                    end
                end
                SLOT_SMP: begin
                    if (phase_done) begin
                        state        <= SLOT_REC;
                        sample_q     <= dq_sync;
                        tmr_start    <= 1'b1;
                        tmr_delay_us <= rec_us;
                    end
                end
                SLOT_REC: begin
                    if (phase_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_bit   <= sample_q;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    dq_oe     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_bit_engine.sv
// Self-checking bench: 1 cycle/us one-shot timer model, open-drain bus with a
// scripted slave, and a spec-level reference for response bits and phase lengths.
module tb_onewire_bit_engine;
    import onewire_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic        cmd_ready, rsp_valid, rsp_bit, busy;
    logic        dq_in, dq_oe, tmr_start, tmr_done;
    logic [15:0] tmr_delay_us;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    onewire_bit_engine dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd          (cmd),
        .rsp_valid    (rsp_valid),
        .rsp_bit      (rsp_bit),
        .busy         (busy),
        .dq_in        (dq_in),
        .dq_oe        (dq_oe),
        .tmr_start    (tmr_start),
        .tmr_delay_us (tmr_delay_us),
        .tmr_done     (tmr_done)
    );

    // One-shot timer model: done one cycle-per-us after start, flags retrigger / unstable delay.
    logic        tmr_done_m = 1'b0;
    logic        spur = 1'b0;
    logic [15:0] t_cnt = 16'd0;
    logic [15:0] t_delay = 16'd0;
    bit          t_run = 1'b0;
    bit          prev_start = 1'b0;
    bit          retrig_seen = 1'b0;
    bit          delay_moved = 1'b0;

    assign tmr_done = tmr_done_m | spur;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_done_m <= 1'b0;
            t_run      <= 1'b0;
            t_cnt      <= 16'd0;
            prev_start <= 1'b0;
        end else begin
            tmr_done_m <= 1'b0;
            prev_start <= tmr_start;
            if (tmr_start) begin
                if (t_run || prev_start) retrig_seen <= 1'b1;
                t_delay <= tmr_delay_us;
                if (tmr_delay_us <= 16'd1) begin
                    tmr_done_m <= 1'b1;
                    t_run      <= 1'b0;
                end else begin
                    t_cnt <= tmr_delay_us - 16'd1;
                    t_run <= 1'b1;
                end
            end else if (t_run) begin
                if (tmr_delay_us != t_delay) delay_moved <= 1'b1;
                if (t_cnt == 16'd1) begin
                    tmr_done_m <= 1'b1;
                    t_run      <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 16'd1;
                end
            end
        end
    end

    // Slave model: presence pulse 15..135 us after release, or a held-low read slot of 30 us.
    typedef enum {SL_IDLE, SL_PRESENCE, SL_READ0} slave_t;
    slave_t slave_mode = SL_IDLE;
    int     since_rise = 100000;
    int     since_fall = 100000;
    logic   dq_oe_q = 1'b0;
    logic   slave_pull;

    always @(posedge clk) begin
        dq_oe_q    <= dq_oe;
        since_rise <= (dq_oe && !dq_oe_q) ? 0 : ((since_rise < 100000) ? since_rise + 1 : since_rise);
        since_fall <= (!dq_oe && dq_oe_q) ? 0 : ((since_fall < 100000) ? since_fall + 1 : since_fall);
    end

    assign slave_pull = (slave_mode == SL_PRESENCE && since_fall >= 15 && since_fall < 135) ||
                        (slave_mode == SL_READ0 && since_rise < 30);
    assign dq_in = (dq_oe || slave_pull) ? 1'b0 : 1'b1;

    // Reference model straight from the bus rules.
    function automatic int ref_low(input cmd_t c);
        if (c == OW_RESET) return 480;
        if (c == OW_WRITE0) return 60;
        return 6;
    endfunction

    function automatic int ref_dur(input cmd_t c);
        return (c == OW_RESET) ? 480 + 70 + 410 : 70;
    endfunction

    function automatic int ref_phases(input cmd_t c);
        return (c == OW_RESET || c == OW_READ) ? 3 : 2;
    endfunction

    function automatic bit ref_bit(input cmd_t c, input bit slave_act);
        case (c)
            OW_RESET: return slave_act;
            OW_READ:  return !slave_act;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input int got, input int lo, input int hi);
        n_checks++;
        assert (got >= lo && got <= hi) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    // Per-command measurements.
    int   n_low, n_dur, n_start;
    bit   got_rsp, ready_leak, busy_drop;
    logic got_bit, post_rsp, post_ready;

    // Issue one command and observe it to completion; hold keeps cmd_valid up with next_cmd, junk toggles inputs.
    task automatic run_cmd(input cmd_t c, input bit hold, input cmd_t next_cmd, input bit junk);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        n_low = 0; n_dur = 0; n_start = 0;
        got_rsp = 1'b0; ready_leak = 1'b0; busy_drop = 1'b0; got_bit = 1'bx;
        guard = 0;
        while (guard < 1500) begin
            @(negedge clk);
            if (dq_oe) n_low++;
            if (tmr_start) n_start++;
            if (cmd_ready) ready_leak = 1'b1;
            if (!busy) busy_drop = 1'b1;
            if (rsp_valid) begin
                got_rsp = 1'b1;
                got_bit = rsp_bit;
                break;
            end
            n_dur++;
            guard++;
            if (hold) begin
                cmd = next_cmd;
            end else if (junk) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd       = 2'($urandom_range(0, 3));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        if (!hold) cmd_valid = 1'b0;
        @(negedge clk);
        post_rsp   = rsp_valid;
        post_ready = cmd_ready;
    endtask

    task automatic verify(input string tag, input cmd_t c, input bit slave_act);
        check({tag, "_rsp_seen"}, 32'(got_rsp), 32'd1);
        check({tag, "_rsp_bit"}, 32'(got_bit), 32'(ref_bit(c, slave_act)));
        check_range({tag, "_low_cycles"}, n_low, ref_low(c), ref_low(c) + 3);
        check_range({tag, "_duration"}, n_dur, ref_dur(c), ref_dur(c) + 3 * ref_phases(c));
        check({tag, "_tmr_starts"}, 32'(n_start), 32'(ref_phases(c)));
        check({tag, "_ready_while_busy"}, 32'(ready_leak), 32'd0);
        check({tag, "_busy_gap"}, 32'(busy_drop), 32'd0);
        check({tag, "_single_rsp"}, 32'(post_rsp), 32'd0);
        check({tag, "_ready_after"}, 32'(post_ready), 32'd1);
    endtask

    initial begin
        cmd_t c;
        bit   act;
        bit   leak;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_bit", 32'(rsp_bit), 32'd0);
        check("rst_dq_oe", 32'(dq_oe), 32'd0);
        check("rst_tmr_start", 32'(tmr_start), 32'd0);
        check("rst_tmr_delay", 32'(tmr_delay_us), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Spurious timer done while idle must not disturb anything.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_ready", 32'(cmd_ready), 32'd1);
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_start", 32'(tmr_start), 32'd0);
        check("spur_rsp", 32'(rsp_valid), 32'd0);

        // RESET with a responding slave, then with an empty bus.
        slave_mode = SL_PRESENCE;
        run_cmd(OW_RESET, 1'b0, OW_RESET, 1'b0);
        verify("reset_present", OW_RESET, 1'b1);
        slave_mode = SL_IDLE;
        run_cmd(OW_RESET, 1'b0, OW_RESET, 1'b0);
        verify("reset_empty", OW_RESET, 1'b0);

        // WRITE0 then WRITE1 with cmd_valid held throughout.
        run_cmd(OW_WRITE0, 1'b1, OW_WRITE1, 1'b0);
        verify("write0", OW_WRITE0, 1'b0);
        run_cmd(OW_WRITE1, 1'b0, OW_WRITE1, 1'b0);
        verify("write1", OW_WRITE1, 1'b0);

        // READ with the slave holding the line, then with the slave idle.
        slave_mode = SL_READ0;
        run_cmd(OW_READ, 1'b0, OW_READ, 1'b0);
        verify("read_zero", OW_READ, 1'b1);
        slave_mode = SL_IDLE;
        run_cmd(OW_READ, 1'b0, OW_READ, 1'b0);
        verify("read_one", OW_READ, 1'b0);

        // READ with junk commands thrown at it while busy.
        run_cmd(OW_READ, 1'b0, OW_READ, 1'b1);
        verify("read_junk", OW_READ, 1'b0);

        // Reset 100 cycles into the reset low phase.
        cmd       = OW_RESET;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (99) @(negedge clk);
        check("abort_dq_before", 32'(dq_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_dq_oe", 32'(dq_oe), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        leak = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (rsp_valid || dq_oe || tmr_start || !cmd_ready) leak = 1'b1;
        end
        check("abort_quiet", 32'(leak), 32'd0);
        slave_mode = SL_PRESENCE;
        run_cmd(OW_RESET, 1'b0, OW_RESET, 1'b0);
        verify("reset_after_abort", OW_RESET, 1'b1);
        slave_mode = SL_IDLE;

        // Randomized commands against the reference model.
        for (int i = 0; i < 8; i++) begin
            c   = cmd_t'($urandom_range(0, 3));
            act = 1'($urandom_range(0, 1));
            if (c == OW_RESET && act) slave_mode = SL_PRESENCE;
            else if (c == OW_READ && act) slave_mode = SL_READ0;
            else slave_mode = SL_IDLE;
            run_cmd(c, 1'b0, c, 1'b0);
            verify($sformatf("rand%0d_%s", i, c.name()), c, (c == OW_RESET || c == OW_READ) ? act : 1'b0);
            slave_mode = SL_IDLE;
        end

        check("timer_never_retriggered", 32'(retrig_seen), 32'd0);
        check("delay_stable_while_running", 32'(delay_moved), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/onewire_bit_engine.md
Name: onewire_bit_engine

Overview:
- Bit-level 1-Wire master sequencer sitting directly upstream of the microsecond one-shot timer (start / delay_us / done).
- Accepts one command per handshake: RESET, WRITE0, WRITE1 or READ.
- Drives the open-drain DQ line, programs the timer for each timed phase and waits for its done pulse.
- Returns presence or read data to the byte-level controller above.

Parameters:
- T_RSTL_US, 480, reset low time.
- T_PDS_US, 70, release-to-presence-sample delay.
- T_RSTR_US, 410, post-sample reset recovery.
- T_W0L_US, 60, write-0 low time.
- T_W1L_US, 6, write-1 / read initiation low time.
- T_RDS_US, 9, release-to-read-sample delay.
- T_SLOT_US, 70, total slot length including recovery. Must exceed every low time plus sample delay.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, engine idle; a command is accepted when cmd_valid and cmd_ready are both high on a clk edge.
- cmd, in, 2, command code: 0 RESET, 1 WRITE0, 2 WRITE1, 3 READ.
- rsp_valid, out, 1, one-cycle pulse at command completion.
- rsp_bit, out, 1, response: presence (1 = device present) for RESET, sampled bit for READ, 0 for writes. Held until the next rsp_valid.
- busy, out, 1, high from acceptance through the rsp_valid cycle.
- dq_in, in, 1, raw bus level, asynchronous.
- dq_oe, out, 1, 1 = pull DQ low; 0 = release (pull-up).
- tmr_start, out, 1, timer start pulse.
- tmr_delay_us, out, 16, timer delay.
- tmr_done, in, 1, timer completion pulse.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs reset to 0 except cmd_ready, which resets to 1. Reset state is IDLE. Reset mid-command releases DQ immediately, drops the command and produces no response; the timer is reset by the same rst.
- dq_in passes through a 2-FF synchronizer, reset value 1. All sampling uses the synchronized value.
- Timed phase rule:
  - On entry to any timed phase, tmr_delay_us is registered and tmr_start is high for exactly one cycle.
  - tmr_delay_us holds stable until tmr_done.
  - The phase ends on the cycle tmr_done is seen high.
  - tmr_start is never asserted again before tmr_done, so the timer is never retriggered while running.
- States: IDLE, RST_LOW, RST_PDS, RST_REC, SLOT_LOW, SLOT_SMP, SLOT_REC, RESP.
- IDLE: cmd_ready=1, dq_oe=0. On acceptance, latch cmd and set busy=1.
  - RESET goes to RST_LOW.
  - Any other command goes to SLOT_LOW.
- RST_LOW: dq_oe=1, delay T_RSTL_US. On done, go to RST_PDS.
- RST_PDS: dq_oe=0, delay T_PDS_US. On done, presence = NOT synchronized DQ, captured in that same cycle. Go to RST_REC.
- RST_REC: dq_oe=0, delay T_RSTR_US. On done, go to RESP.
- SLOT_LOW: dq_oe=1, delay T_W0L_US for WRITE0, otherwise T_W1L_US. On done:
  - READ goes to SLOT_SMP.
  - Writes go to SLOT_REC.
- SLOT_SMP: dq_oe=0, delay T_RDS_US. On done, capture synchronized DQ as the read bit and go to SLOT_REC.
- SLOT_REC: dq_oe=0, delay = T_SLOT_US − (low time + sample delay if READ). Computed with 16-bit unsigned arithmetic; a zero result still issues a start with delay 0. On done, go to RESP.
- RESP: rsp_valid=1 for one cycle, rsp_bit updated. Go to IDLE, where busy=0 and cmd_ready=1 in the following cycle.
- cmd_valid while busy: ignored, and cmd must not be latched.
- A spurious tmr_done outside a timed phase is ignored.
- dq_oe is a registered output, so it is glitch-free.

Decomposition:
- Package onewire_pkg holds:
  - enum cmd_t: OW_RESET, OW_WRITE0, OW_WRITE1, OW_READ.
  - enum state_t listing the states above.
  - default timing localparams, shared with the timer's users.
- One sub-module: onewire_sync2, the 2-FF synchronizer with reset value 1.

Test Plan:
- Common bench setup: instantiate with the real timer at CLK_FREQ=1_000_000 (1 cycle/us) and an open-drain bus model with a pull-up. Phase durations may exceed the nominal delay by 1–3 cycles; the bench checks that window.
- RESET with a slave model pulling low from 15 us to 135 us after release -> dq_oe high for 480 (+≤3) cycles; rsp_valid with rsp_bit=1; total duration ≈ 960 cycles.
- RESET with no slave -> rsp_bit=0; timing identical to the previous case.
- WRITE0 then WRITE1 back-to-back (cmd_valid held) -> low pulses of 60 and 6 cycles; each slot ≈ 70 cycles; two rsp_valid pulses with rsp_bit=0; second command accepted only after cmd_ready returns.
- READ with the slave holding DQ low for 30 us from slot start -> rsp_bit=0. READ with the slave idle -> rsp_bit=1. Low pulse = 6 cycles.
- cmd_valid toggled with other codes during a READ -> ignored; exactly one response; tmr_start pulses exactly 3 times.
- rst asserted 100 cycles into RST_LOW -> dq_oe=0 asynchronously; cmd_ready=1, rsp_valid never pulses; a new RESET after release runs from a clean start.
